nios_system_led_pio_blink: RTL and testbench

Parametrised Avalon-MM slave output port driving board LEDs from the Nios II system.
- Writable data register with atomic set/clear/toggle aliases, so software needs no read-modify-write.
- Per-bit hardware blink mode driven by a programmable prescaler.
- Sits on the system interconnect as a zero-wait-state, read-latency-0 slave. out_port goes to the LED pins.

---
 rtl/nios_system_led_pio_blink_pkg.sv | 11 +
 rtl/nios_system_led_pio_blink_if.sv | 10 +
 rtl/nios_system_led_pio_blink_prescaler.sv | 31 +++
 rtl/nios_system_led_pio_blink.sv | 49 ++++
 tb/tb_nios_system_led_pio_blink.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/nios_system_led_pio_blink_pkg.sv
// nios_led_pio_pkg: register offsets and status bit positions for the LED PIO
package nios_led_pio_pkg;
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd3;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd4;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;
  localparam int PHASE_BIT = 0;
endpackage

// File: rtl/nios_system_led_pio_blink_if.sv
// nios_system_led_pio_blink_if: Avalon-MM slave bus for the LED PIO
interface nios_system_led_pio_blink_if;
  logic [2:0] address;
  logic chipselect;
  logic write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_led_pio_blink_prescaler.sv
// led_blink_prescaler: half-period counter producing the shared blink phase
module led_blink_prescaler #(
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic [PRESCALE_WIDTH-1:0] load_value,
  output logic phase,
  output logic [PRESCALE_WIDTH-1:0] period
);
  logic [PRESCALE_WIDTH-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      period <= '0;
      cnt <= '0;
      phase <= 1'b1;
    end else if (load) begin
      period <= load_value;
      cnt <= load_value;
      phase <= 1'b1;
    end else if (period == '0) begin
      cnt <= '0;
      phase <= 1'b1;
    end else if (cnt == '0) begin
      cnt <= period;
      phase <= ~phase;
    end else begin
      cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/nios_system_led_pio_blink.sv
// nios_system_led_pio_blink: Avalon-MM LED output port with set/clear/toggle aliases and blink
module nios_system_led_pio_blink
  import nios_led_pio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int PRESCALE_WIDTH = 24
) (
  input  logic clk,
  input  logic reset_n,
  nios_system_led_pio_blink_if.slave bus,
  output logic [DATA_WIDTH-1:0] out_port
);
  logic we, phase, unused_wd;
  logic [DATA_WIDTH-1:0] wd, data_out, data_nxt, blink_en;
  logic [PRESCALE_WIDTH-1:0] period;
  assign we = bus.chipselect && !bus.write_n;
  assign wd = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^bus.writedata;
  led_blink_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk,
    .reset_n,
    .load(we && bus.address == ADDR_PERIOD),
    .load_value(bus.writedata[PRESCALE_WIDTH-1:0]),
    .phase,
    .period
  );
  always_comb
    data_nxt = !we ? data_out :
               bus.address == ADDR_DATA   ? wd :
               bus.address == ADDR_OUTSET ? data_out | wd :
               bus.address == ADDR_OUTCLR ? data_out & ~wd :
               bus.address == ADDR_TOGGLE ? data_out ^ wd : data_out;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      blink_en <= '0;
    end else begin
      data_out <= data_nxt;
      if (we && bus.address == ADDR_BLINK_EN) blink_en <= wd;
    end
  always_comb
    bus.readdata = bus.address == ADDR_DATA     ? 32'(data_out) :
                   bus.address == ADDR_BLINK_EN ? 32'(blink_en) :
                   bus.address == ADDR_PERIOD   ? 32'(period) :
                   bus.address == ADDR_STATUS   ? 32'(phase) << PHASE_BIT : '0;
  // blinking bits gate the data value rather than replace it
  assign out_port = data_out & (~blink_en | {DATA_WIDTH{phase}});
endmodule

// File: tb/tb_nios_system_led_pio_blink.sv
// tb_nios_system_led_pio_blink: directed and random checks against a time-based blink model
module tb_nios_system_led_pio_blink;
  localparam int DW = 8;
  localparam int PW = 24;
  localparam logic [7:0] RV = 8'h3C;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [DW-1:0] out_port;
  nios_system_led_pio_blink_if bus();
  nios_system_led_pio_blink #(.DATA_WIDTH(DW), .RESET_VALUE(RV), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave),
    .out_port(out_port)
  );
  always #5 clk = ~clk;
  int n_pass = 0;
  int n_total = 0;
  logic [7:0] m_data, m_blink;
  logic [23:0] m_period;
  int m_k;
  // phase is a pure function of clocks elapsed since the last PERIOD write
  function automatic logic m_phase();
    return (m_period == 0) ? 1'b1 : ((m_k / (int'(m_period) + 1)) % 2 == 0);
  endfunction
  function automatic logic [7:0] m_out();
    return m_data & (~m_blink | {8{m_phase()}});
  endfunction
  function automatic logic [31:0] m_rd(input logic [2:0] a);
    case (a)
      3'd0: return {24'b0, m_data};
      3'd1: return {24'b0, m_blink};
      3'd2: return {8'b0, m_period};
      3'd6: return {31'b0, m_phase()};
      default: return 32'b0;
    endcase
  endfunction
  task automatic m_reset();
    m_data = RV;
    m_blink = 0;
    m_period = 0;
    m_k = 0;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic rd(input logic [2:0] a, input string tag);
    bus.address = a;
    #1;
    chk(tag, bus.readdata, m_rd(a));
  endtask
  task automatic tick(input logic we, input logic [2:0] a, input logic [31:0] wd);
    @(posedge clk);
    if (we && a == 3'd2) begin
      m_period = wd[23:0];
      m_k = 0;
    end else begin
      m_k++;
      if (we)
        case (a)
          3'd0: m_data = wd[7:0];
          3'd1: m_blink = wd[7:0];
          3'd3: m_data = m_data | wd[7:0];
          3'd4: m_data = m_data & ~wd[7:0];
          3'd5: m_data = m_data ^ wd[7:0];
          default: ;
        endcase
    end
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic cs = 1'b1);
    bus.address = a;
    bus.writedata = wd;
    bus.chipselect = cs;
    bus.write_n = 1'b0;
    tick(cs, a, wd);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      tick(1'b0, 3'd0, 32'd0);
      chk("out_idle", {24'b0, out_port}, {24'b0, m_out()});
      rd(3'd6, "status_idle");
    end
  endtask
  initial begin
    bus.address = 0;
    bus.chipselect = 0;
    bus.write_n = 1;
    bus.writedata = 0;
    m_reset();
    #12;
    chk("rst_out", {24'b0, out_port}, 32'h3C);
    rd(3'd0, "rst_rd0");
    chk("rst_rd0_const", bus.readdata, 32'h3C);
    rd(3'd1, "rst_rd1");
    rd(3'd2, "rst_rd2");
    rd(3'd6, "rst_status");
    chk("rst_status_const", bus.readdata, 32'h1);
    reset_n = 1'b1;
    wr(3'd0, 32'hA5);
    chk("data_a5", {24'b0, out_port}, 32'hA5);
    rd(3'd0, "rd_a5");
    wr(3'd0, 32'h1FF, 1'b0);
    chk("cs_low", {24'b0, out_port}, 32'hA5);
    wr(3'd0, 32'hFFFFFF5A);
    chk("upper_drop", {24'b0, out_port}, 32'h5A);
    rd(3'd0, "rd_5a");
    wr(3'd0, 32'hA5);
    wr(3'd3, 32'h0F);
    chk("outset", {24'b0, out_port}, 32'hAF);
    wr(3'd4, 32'h81);
    chk("outclr", {24'b0, out_port}, 32'h2E);
    wr(3'd5, 32'hFF);
    chk("toggle", {24'b0, out_port}, 32'hD1);
    wr(3'd7, 32'hFF);
    chk("reserved_wr", {24'b0, out_port}, 32'hD1);
    rd(3'd3, "rd3");
    rd(3'd4, "rd4");
    rd(3'd5, "rd5");
    rd(3'd7, "rd7");
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'h0F);
    wr(3'd2, 32'd3);
    rd(3'd2, "rd_period");
    chk("blink_k0", {24'b0, out_port}, 32'hFF);
    for (int i = 1; i < 16; i++) begin
      tick(1'b0, 3'd0, 32'd0);
      chk("blink_seq", {24'b0, out_port}, ((i / 4) % 2 == 0) ? 32'hFF : 32'hF0);
      rd(3'd6, "blink_status");
    end
    wr(3'd2, 32'd0);
    idle(6);
    chk("period0_steady", {24'b0, out_port}, 32'hFF);
    wr(3'd2, 32'd3);
    idle(3);
    wr(3'd2, 32'd1);
    rd(3'd6, "exp_ph_a");
    chk("exp_ph_a_const", bus.readdata, 32'h1);
    idle(1);
    chk("exp_ph_b", {24'b0, out_port}, 32'hFF);
    idle(1);
    chk("exp_ph_c", {24'b0, out_port}, 32'hF0);
    idle(4);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] a;
      logic [31:0] wd;
      a = 3'($urandom_range(0, 7));
      wd = (a == 3'd2) ? $urandom_range(0, 4) : $urandom;
      wr(a, wd, $urandom_range(0, 3) != 0);
      chk("rand_out", {24'b0, out_port}, {24'b0, m_out()});
      rd(3'($urandom_range(0, 7)), "rand_rd");
    end
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'd2);
    idle(4);
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("async_rst", {24'b0, out_port}, 32'h3C);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(4);
    wr(3'd0, 32'hFF);
    wr(3'd1, 32'hFF);
    idle(10);
    chk("no_blink_after_rst", {24'b0, out_port}, 32'hFF);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
